// File: rtl/aes_key_expand.sv
// aes_key_expand: iterative AES-128 key schedule, one round key per cycle into an 11-entry bank.
// Words are little-endian byte packed: key byte i sits at key_in[8i+7:8i], word k at [32k+31:32k].
module aes_key_expand #(
  parameter int NR    = 10,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [127:0]     key_in,
  input  logic [IDX_W-1:0] rk_idx,
  output logic [127:0]     rk_out,
  output logic             busy,
  output logic             done,
  output logic             keys_valid
);
  typedef enum logic {IDLE, EXPAND} state_t;
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [0:10][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };
  state_t state, state_next;
  logic [3:0]   round;
  logic [127:0] prev, next_key;
  logic [127:0] bank [0:NR];
  logic [31:0]  w3, t, n0, n1, n2, n3;
  // RotWord in this packing moves byte 0 to the top: {w3[7:0], w3[31:8]}
  assign w3 = prev[127:96];
  assign t  = {SBOX[w3[7:0]], SBOX[w3[31:24]], SBOX[w3[23:16]], SBOX[w3[15:8]]}
              ^ {24'h0, RCON[round]};
  assign n0 = prev[31:0] ^ t;
  assign n1 = prev[63:32] ^ n0;
  assign n2 = prev[95:64] ^ n1;
  assign n3 = w3 ^ n2;
  assign next_key = {n3, n2, n1, n0};
  assign rk_out = (rk_idx > IDX_W'(NR)) ? '0 : bank[rk_idx];
  always_comb begin
    state_next = state;
    state_next = (state == IDLE) ? (start ? EXPAND : IDLE)
                                 : ((round == 4'(NR)) ? IDLE : EXPAND);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      round      <= '0;
      prev       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
      for (int i = 0; i <= NR; i++) bank[i] <= '0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      if (state == IDLE && start) begin
        bank[0]    <= key_in;
        prev       <= key_in;
        round      <= 4'd1;
        busy       <= 1'b1;
        keys_valid <= 1'b0;
      end else if (state == EXPAND) begin
        bank[round] <= next_key;
        prev        <= next_key;
        if (round == 4'(NR)) begin
          busy       <= 1'b0;
          done       <= 1'b1;
          keys_valid <= 1'b1;
        end else begin
          round <= round + 4'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand: directed FIPS-197 vectors; expected round keys are queued at start and
// checked by a monitor whenever done pulses.
module tb_aes_key_expand;
  typedef struct {
    logic [127:0] k0;
    logic [31:0]  w4;
    logic [127:0] k10;
  } exp_t;
  localparam logic [127:0] K2  = 128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b;
  localparam logic [127:0] K3  = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
  localparam exp_t E2 = '{K2, 32'h17fefaa0, 128'ha60c63b6_c80c3fe1_8925eec9_a8f914d0};
  localparam exp_t E3 = '{K3, 32'hfd74aad6, 128'hc5302b4d_8ba707f3_174a94e3_7f1d1113};
  logic         clk = 1'b0;
  logic         reset_n, start;
  logic [127:0] key_in, rk_out;
  logic [3:0]   rk_idx, stim_idx, mon_idx;
  logic         mon_active = 1'b0;
  logic         busy, done, keys_valid;
  int           tests = 0, fails = 0, done_cnt = 0;
  exp_t         q[$];
  assign rk_idx = mon_active ? mon_idx : stim_idx;
  aes_key_expand dut (
    .clk(clk), .reset_n(reset_n), .start(start), .key_in(key_in), .rk_idx(rk_idx),
    .rk_out(rk_out), .busy(busy), .done(done), .keys_valid(keys_valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Monitor: every done pulse must match the oldest outstanding expansion
  initial forever begin
    @(negedge clk);
    if (done) begin
      done_cnt++;
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        mon_active = 1'b1;
        mon_idx = 4'd0;  #1 chk("rk0", rk_out, e.k0);
        mon_idx = 4'd1;  #1 chk("rk1_w0", {96'h0, rk_out[31:0]}, {96'h0, e.w4});
        mon_idx = 4'd10; #1 chk("rk10", rk_out, e.k10);
        chk("done_keys_valid", keys_valid, 1);
        chk("done_busy", busy, 0);
        mon_active = 1'b0;
      end
    end
  end
  task automatic launch(input logic [127:0] k, input exp_t e, input bit push);
    @(negedge clk);
    start = 1'b1;
    key_in = k;
    if (push) q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done_timeout", done, 1);
  endtask
  initial begin
    int n;
    int d0;
    bit kv_seen;
    reset_n = 1'b0; start = 1'b0; key_in = '0; stim_idx = '0;
    // T1 reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_keys_valid", keys_valid, 0);
    for (int i = 0; i < 16; i++) begin
      stim_idx = 4'(i);
      #1 chk($sformatf("rst_rk%0d", i), rk_out, 0);
    end
    @(negedge clk) reset_n = 1'b1;
    // T2 FIPS-197 A.1 with busy length
    launch(K2, E2, 1);
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", n, 10);
    chk("done_after_busy", done, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    // T6 out-of-range indices
    for (int i = 11; i < 16; i++) begin
      stim_idx = 4'(i);
      #1 chk($sformatf("oor_rk%0d", i), rk_out, 0);
    end
    chk("kv_after_t2", keys_valid, 1);
    // T3 FIPS-197 C.1
    launch(K3, E3, 1);
    wait_done();
    @(negedge clk);
    // T4 start while busy is ignored
    d0 = done_cnt;
    launch(K2, E2, 1);
    repeat (3) @(negedge clk);
    start = 1'b1;
    key_in = K3;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);
    chk("t4_done_once", done_cnt - d0, 1);
    chk("t4_idle", busy, 0);
    // T5 reset mid-expansion
    launch(K3, E3, 0);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_keys_valid", keys_valid, 0);
    for (int i = 0; i < 11; i++) begin
      stim_idx = 4'(i);
      #1 chk($sformatf("t5_rk%0d", i), rk_out, 0);
    end
    @(negedge clk) reset_n = 1'b1;
    launch(K2, E2, 1);
    wait_done();
    @(negedge clk);
    // T7 back-to-back start in the done cycle
    launch(K3, E3, 1);
    wait_done();
    start = 1'b1;
    key_in = K2;
    q.push_back(E2);
    @(negedge clk);
    start = 1'b0;
    chk("t7_busy", busy, 1);
    chk("t7_kv_low", keys_valid, 0);
    kv_seen = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      if (keys_valid) kv_seen = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("t7_kv_stayed_low", kv_seen, 0);
    chk("t7_done", done, 1);
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
